// File: rtl/nist04_pattern_gen_if.sv
// nist04_pattern_gen_if: control and serial-stream signals of the longest-run stimulus source
interface nist04_pattern_gen_if;
  logic start;
  logic [1:0] mode;
  logic [1:0] cls_in;
  logic ready;
  logic bit_out;
  logic bit_valid;
  logic blk_first;
  logic cls_ack;
  logic busy;
  logic done;
  modport master (output start, mode, cls_in, ready, input bit_out, bit_valid, blk_first, cls_ack, busy, done);
  modport slave (input start, mode, cls_in, ready, output bit_out, bit_valid, blk_first, cls_ack, busy, done);
endinterface

// File: rtl/nist04_pattern_gen.sv
// nist04_pattern_gen: serial 8-bit block source (raw LFSR or shaped longest-run class) for the NIST04 checker
module nist04_pattern_gen #(
  parameter int N_BLKS = 16,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input logic clk,
  input logic rstn,
  nist04_pattern_gen_if.slave io
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3;
  logic [1:0] state, mode;
  logic [15:0] lfsr, lfsr_nxt;
  logic [7:0] blk, blk_nxt, src_lo;
  logic [1:0] src_hi;
  logic [2:0] bit_idx, run;
  logic [3:0] blk_idx;
  logic acc, last_bit, last_blk, load;
  assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign acc = state == SHIFT && io.ready;
  assign last_bit = acc && bit_idx == 3'd7;
  assign last_blk = blk_idx == 4'(N_BLKS - 1);
  assign load = state == LOAD || (last_bit && !last_blk);
  // block 0 uses the seed as-is; later blocks use the value after the boundary step
  assign src_lo = state == LOAD ? lfsr[7:0] : lfsr_nxt[7:0];
  assign src_hi = state == LOAD ? lfsr[15:14] : lfsr_nxt[15:14];
  assign run = io.cls_in == 2'd3 ? 3'd4 + {1'b0, src_hi} : {1'b0, io.cls_in} + 3'd1;
  // run ones, a zero, then filler masked to 1010.. so no filler run can reach the run length
  assign blk_nxt = mode == 2'b00 ? src_lo :
                   mode == 2'b10 ? 8'hFF :
                   mode == 2'b11 ? 8'h55 :
                   ~(8'hFF >> run) | (src_lo & (8'hAA >> ({1'b0, run} + 4'd1)));
  assign io.bit_valid = state == SHIFT;
  assign io.bit_out = state == SHIFT && blk[3'd7 - bit_idx];
  assign io.blk_first = state == SHIFT && bit_idx == 3'd0;
  assign io.cls_ack = load && mode == 2'b01;
  assign io.busy = state == LOAD || state == SHIFT;
  assign io.done = state == DONE;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      mode <= 2'b00;
      lfsr <= SEED;
      blk <= 8'h00;
      bit_idx <= 3'd0;
      blk_idx <= 4'd0;
    end else begin
      if (state == IDLE && io.start) begin
        state <= LOAD;
        mode <= io.mode;
        lfsr <= SEED;
        bit_idx <= 3'd0;
        blk_idx <= 4'd0;
      end
      if (state == LOAD) state <= SHIFT;
      if (state == DONE) state <= IDLE;
      if (load) blk <= blk_nxt;
      if (acc) begin
        lfsr <= lfsr_nxt;
        bit_idx <= bit_idx + 3'd1;
      end
      if (last_bit) begin
        if (last_blk) state <= DONE;
        else blk_idx <= blk_idx + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_nist04_pattern_gen.sv
// tb_nist04_pattern_gen: directed windows in every mode, reset mid-window, random ready and stray starts
module tb_nist04_pattern_gen;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int total = 0;
  int bad = 0;
  nist04_pattern_gen_if io();
  nist04_pattern_gen #(.N_BLKS(16), .SEED(16'hACE1)) dut (.clk(clk), .rstn(rstn), .io(io));
  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // expected 128-bit stream, first bit at [127], built bit by bit from the block recipe
  function automatic logic [127:0] model(input logic [1:0] m, input logic [1:0] c);
    logic [15:0] r;
    logic [127:0] s;
    logic v;
    int L;
    r = 16'hACE1;
    s = '0;
    for (int b = 0; b < 16; b++) begin
      L = (c == 2'd3) ? 4 + int'(r[15:14]) : int'(c) + 1;
      for (int j = 0; j < 8; j++) begin
        case (m)
          2'b00: v = r[7-j];
          2'b10: v = 1'b1;
          2'b11: v = (j % 2 == 1);
          default: v = (j < L) ? 1'b1 : (j == L) ? 1'b0 : (r[7-j] & ((j - L - 1) % 2 == 0));
        endcase
        s[127-(b*8+j)] = v;
      end
      for (int j = 0; j < 8; j++) r = step(r);
    end
    return s;
  endfunction

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // k=0 is the LOAD cycle; stops on done, on cut accepted bits, or after a bounded number of cycles
  task automatic window(input logic [1:0] m, input logic [1:0] c, input bit rnd, input int cut,
                        output logic [127:0] bits, output int nacc, output int ndone, output int nack,
                        output int nfirst, output int t_first, output int t_done);
    bits = '0;
    nacc = 0;
    ndone = 0;
    nack = 0;
    nfirst = 0;
    t_first = -1;
    t_done = -1;
    io.mode = m;
    io.cls_in = c;
    io.ready = 1'b1;
    io.start = 1'b1;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      io.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      io.start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (io.bit_valid && io.ready) begin
        if (nacc < 128) bits[127-nacc] = io.bit_out;
        if (t_first < 0) t_first = k;
        if (io.blk_first) nfirst++;
        nacc++;
      end
      if (io.cls_ack) nack++;
      if (io.done) begin
        ndone++;
        t_done = k;
      end
      if (io.done || (cut > 0 && nacc == cut)) break;
      @(posedge clk);
      #1;
    end
    io.start = 1'b0;
    io.ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] ref0, got;
    logic [7:0] hb [4];
    int na, nd, nk, nf, tf, td, extra;
    hb[0] = 8'hA0;
    hb[1] = 8'hC1;
    hb[2] = 8'hE0;
    hb[3] = 8'hFD;
    io.start = 1'b0;
    io.mode = 2'b00;
    io.cls_in = 2'b00;
    io.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chki("rst_outs", 32'({io.bit_out, io.bit_valid, io.blk_first, io.cls_ack, io.busy, io.done}), 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chki("idle_outs", 32'({io.bit_out, io.bit_valid, io.blk_first, io.cls_ack, io.busy, io.done}), 0);

    ref0 = model(2'b00, 2'b00);
    window(2'b00, 2'b00, 1'b0, 0, got, na, nd, nk, nf, tf, td);
    chki("m00_first_byte", 32'(got[127:120]), 32'hE1);
    chkw("m00_stream", got, ref0);
    chki("m00_count", na, 128);
    chki("m00_first_lat", tf, 1);
    chki("m00_done_lat", td, 129);
    chki("m00_done_cnt", nd, 1);
    chki("m00_blk_first", nf, 16);
    chki("m00_ack", nk, 0);
    chki("m00_idle_after", 32'({io.busy, io.done, io.bit_valid}), 0);

    window(2'b10, 2'b00, 1'b0, 0, got, na, nd, nk, nf, tf, td);
    chkw("m10_stream", got, {128{1'b1}});
    chki("m10_blk_first", nf, 16);
    chki("m10_done_cnt", nd, 1);

    window(2'b11, 2'b00, 1'b0, 0, got, na, nd, nk, nf, tf, td);
    chkw("m11_stream", got, {16{8'h55}});

    for (int c = 0; c < 4; c++) begin
      window(2'b01, 2'(c), 1'b0, 0, got, na, nd, nk, nf, tf, td);
      chki($sformatf("m01_c%0d_first_byte", c), 32'(got[127:120]), 32'(hb[c]));
      chkw($sformatf("m01_c%0d_stream", c), got, model(2'b01, 2'(c)));
      chki($sformatf("m01_c%0d_ack", c), nk, 16);
    end

    window(2'b00, 2'b00, 1'b0, 37, got, na, nd, nk, nf, tf, td);
    chki("mid_count", na, 37);
    chki("mid_busy", 32'(io.busy), 1);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chki("mid_rst_outs", 32'({io.bit_out, io.bit_valid, io.blk_first, io.cls_ack, io.busy, io.done}), 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    window(2'b00, 2'b00, 1'b0, 0, got, na, nd, nk, nf, tf, td);
    chkw("replay_stream", got, ref0);

    window(2'b00, 2'b00, 1'b1, 0, got, na, nd, nk, nf, tf, td);
    chkw("rnd_stream", got, ref0);
    chki("rnd_count", na, 128);
    extra = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (io.done) extra++;
    end
    chki("rnd_done_once", nd + extra, 1);
    chki("rnd_idle", 32'(io.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
